raster_line_tracker: RTL and testbench
======================================

Name: raster_line_tracker

Overview:
- Sits directly upstream of the HPS extension command handler.
- Derives the current video line number from the core's raw hsync/vsync in the clk_sys domain and presents it as vga_vcount.
- Generates the hps_rise toggle once per frame at a programmable line, so HPS software can pace frame uploads against the raster.
- Gated by cmd_init, the init flag written by HPS; it also reports measured frame height and a lock indication.

Parameters:
- HS_POL, 1, hsync active level (1 = active-high).
- VS_POL, 1, vsync active level (1 = active-high).
- CW, 16, line counter width; vga_vcount and lines_total are CW bits.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- hsync  in  1  raw horizontal sync, already in the clk_sys domain.
- vsync  in  1  raw vertical sync, already in the clk_sys domain.
- cmd_init  in  1  HPS init flag; 1 enables hps_rise generation.
- irq_line  in  CW  line number at which hps_rise toggles.
- vga_vcount  out  CW  current line; 0 = first line after vsync leading edge.
- hps_rise  out  1  toggles once per frame when line == irq_line and the tracker is armed.
- lines_total  out  CW  line count of the last completed frame.
- locked  out  1  high while the last two completed frames had equal lines_total.

Behaviour:
- Reset values:
  - vga_vcount = 0, hps_rise = 0, lines_total = 0, locked = 0.
  - Internal sync registers = inactive level.
  - State = IDLE.
- Input normalisation: hs = hsync ^ ~HS_POL and vs = vsync ^ ~VS_POL, so both are active-high internally.
- Edge detection:
  - hs and vs are registered into s1, then s1 into s2.
  - hs_edge = hs_s1 & ~hs_s2; vs_edge = vs_s1 & ~vs_s2.
  - Latency: a sync leading edge at input appears as an updated vga_vcount 2 clk_sys cycles later.
- Line counter:
  - On vs_edge: vga_vcount <= 0.
    - Also lines_total <= vga_vcount + 1, saturating at all-ones.
    - Also locked <= (new lines_total == old lines_total) && old lines_total != 0.
  - On hs_edge without vs_edge: vga_vcount <= vga_vcount + 1, saturating at all-ones (no wrap).
  - hs_edge and vs_edge in the same cycle: vsync wins; the count becomes 0, not 1.
  - A missing vsync lets the count saturate; locked stays at its last value until the next vs_edge.
- Match pulse:
  - match = (next vga_vcount value == irq_line), evaluated in the cycle vga_vcount is written.
  - This covers both the vs_edge write (irq_line = 0 matches) and hs_edge writes.
- FSM states: IDLE, WAIT_VS, ARMED, FIRED.
  - IDLE: entered on reset or whenever cmd_init == 0, from any state, with priority over everything else. hps_rise holds its value. Exit to WAIT_VS when cmd_init == 1.
  - WAIT_VS: waits for vs_edge, so a partial frame never fires. On vs_edge go to ARMED; if match also occurs in that cycle (irq_line == 0), toggle hps_rise and go to FIRED.
  - ARMED: on match, toggle hps_rise and go to FIRED.
  - FIRED: on vs_edge go to ARMED, or toggle and stay in FIRED if irq_line == 0.
- At most one toggle per frame.
- irq_line >= lines_total means no toggle occurs that frame; this is not an error.
- irq_line changes take effect at the next comparison; no toggle is re-issued within a frame.
- Counting and lines_total/locked update continue in every state; only hps_rise is gated.
- Reset mid-frame: all outputs return to reset values next cycle. The first toggle requires cmd_init = 1, then a vs_edge, then a match.

Decomposition:
- Shared package raster_pkg holds:
  - FSM state enum (IDLE, WAIT_VS, ARMED, FIRED).
  - CW default.
  - Saturation constant LINE_MAX = all-ones of CW.
- One natural sub-module, sync_edge_det: per-signal polarity normalise, two-stage register, leading-edge pulse. It is instantiated for hsync and vsync.

Test Plan:
1. Reset, then 262-line frames (vsync every 262 hsyncs), irq_line = 240, cmd_init = 1 → no toggle in the first partial frame. hps_rise goes 0→1 at vcount 240 of frame 2 and 1→0 in frame 3. lines_total = 262; locked = 1 after the second full frame.
2. Simultaneous hsync and vsync leading edge → vga_vcount = 0 two cycles later (not 1). Next hsync → 1.
3. irq_line = 0 → exactly one toggle per frame, coincident with the vs_edge update. irq_line = 300 with 262-line frames → no toggles over 3 frames.
4. Drop cmd_init to 0 mid-frame after a toggle → hps_rise holds. Re-assert at line 100 with irq_line = 200 → no toggle at line 200 of the current frame; toggle at line 200 of the next frame.
5. Frame heights 262, 263, 263 → locked = 0, 0, 1. Suppress vsync for 70000 hsyncs → vga_vcount saturates at 65535 and never wraps.
6. HS_POL = 0, VS_POL = 0 with inverted syncs → identical vcount/hps_rise behaviour to scenario 1. Reset asserted at line 150 → all outputs 0 next cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared definitions for the raster line tracker.
//   CW_DEF   : default line counter width
//   LINE_MAX : saturation value of a CW_DEF-wide line counter
//   state_t  : hps_rise arming state machine encoding
package raster_pkg;

  localparam int CW_DEF = 16;
  localparam logic [CW_DEF-1:0] LINE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ARMED,
    FIRED
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Polarity-normalising leading-edge detector for one raw sync signal that is
// already in the clk_sys domain.
//   clk_sys    : system clock
//   reset      : synchronous active-high reset (registers go to inactive level)
//   sync_raw   : raw sync input, active level given by POL
//   edge_pulse : one-cycle pulse after the sync becomes active
module sync_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic sync_raw,
  output logic edge_pulse
);

  logic sync_act;
  logic sync_s1;
  logic sync_s2;

  // Flip an active-low sync so everything downstream sees active-high.
  assign sync_act = sync_raw ^ ~POL;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_s1 <= 1'b0;
      sync_s2 <= 1'b0;
    end else begin
      sync_s1 <= sync_act;
      sync_s2 <= sync_s1;
    end
  end

  // ---- stage boundary: s1/s2 -> edge pulse ----
  assign edge_pulse = sync_s1 & ~sync_s2;

endmodule

// File: rtl/raster_line_tracker.sv
// Raster line tracker.
// Counts video lines from raw hsync/vsync, reports the height of the last
// frame and whether the frame height is stable, and toggles hps_rise once per
// frame at a programmable line so HPS software can pace its uploads.
//   clk_sys     : system clock
//   reset       : synchronous active-high reset
//   hsync/vsync : raw syncs in the clk_sys domain (polarity HS_POL/VS_POL)
//   cmd_init    : HPS init flag, enables hps_rise generation
//   irq_line    : line number at which hps_rise toggles
//   vga_vcount  : current line, 0 = first line after vsync leading edge
//   hps_rise    : toggles once per frame at irq_line when armed
//   lines_total : line count of the last completed frame
//   locked      : last two completed frames had the same height
module raster_line_tracker
  import raster_pkg::*;
#(
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int CW     = CW_DEF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          cmd_init,
  input  logic [CW-1:0] irq_line,
  output logic [CW-1:0] vga_vcount,
  output logic          hps_rise,
  output logic [CW-1:0] lines_total,
  output logic          locked
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  logic          hs_edge;
  logic          vs_edge;
  logic          match;
  logic [CW-1:0] line_inc;
  logic [CW-1:0] vcount_next;
  state_t        state;

  sync_edge_det #(.POL(HS_POL)) u_hs_det (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .sync_raw   (hsync),
    .edge_pulse (hs_edge)
  );

  sync_edge_det #(.POL(VS_POL)) u_vs_det (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .sync_raw   (vsync),
    .edge_pulse (vs_edge)
  );

  // ---- stage boundary: edge pulses -> line counter ----
  assign line_inc = sat_inc(vga_vcount);

  // vsync has priority: a coincident hsync must not make the first line 1.
  always_comb begin
    vcount_next = vga_vcount;
    if (vs_edge) begin
      vcount_next = '0;
    end else if (hs_edge) begin
      vcount_next = line_inc;
    end
  end

  // Compare against the value being written so irq_line 0 hits on vs_edge.
  assign match = (vs_edge | hs_edge) && (vcount_next == irq_line);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vga_vcount  <= '0;
      lines_total <= '0;
      locked      <= 1'b0;
    end else begin
      vga_vcount <= vcount_next;
      if (vs_edge) begin
        lines_total <= line_inc;
        locked      <= (line_inc == lines_total) && (lines_total != '0);
      end
    end
  end

  // ---- stage boundary: match -> hps_rise state machine ----
  // WAIT_VS keeps a partially observed frame from firing; FIRED blocks a
  // second toggle until the next frame starts.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      hps_rise <= 1'b0;
    end else if (!cmd_init) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: state <= WAIT_VS;
        WAIT_VS: begin
          if (vs_edge) begin
            if (match) begin
              hps_rise <= ~hps_rise;
              state    <= FIRED;
            end else begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (match) begin
            hps_rise <= ~hps_rise;
            state    <= FIRED;
          end
        end
        FIRED: begin
          if (vs_edge) begin
            if (match) begin
              hps_rise <= ~hps_rise;
            end else begin
              state <= ARMED;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_line_tracker.sv
// Testbench for raster_line_tracker: three instances share one stimulus
// (16-bit active-high syncs, 16-bit active-low syncs, 10-bit counter for
// quick saturation) and are compared every cycle with a frame-level model.
module tb_raster_line_tracker;
  import raster_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync;
  logic        vsync;
  logic        cmd_init;
  logic [15:0] irq_line;
  logic        hsync_n;
  logic        vsync_n;

  logic [15:0] v16, t16, v16n, t16n;
  logic        r16, l16, r16n, l16n;
  logic [9:0]  v10, t10;
  logic        r10, l10;

  assign hsync_n = ~hsync;
  assign vsync_n = ~vsync;

  always #5 clk = ~clk;

  raster_line_tracker #(.HS_POL(1'b1), .VS_POL(1'b1), .CW(16)) dut_p (
    .clk_sys(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .cmd_init(cmd_init), .irq_line(irq_line),
    .vga_vcount(v16), .hps_rise(r16), .lines_total(t16), .locked(l16));

  raster_line_tracker #(.HS_POL(1'b0), .VS_POL(1'b0), .CW(16)) dut_n (
    .clk_sys(clk), .reset(reset), .hsync(hsync_n), .vsync(vsync_n),
    .cmd_init(cmd_init), .irq_line(irq_line),
    .vga_vcount(v16n), .hps_rise(r16n), .lines_total(t16n), .locked(l16n));

  raster_line_tracker #(.HS_POL(1'b1), .VS_POL(1'b1), .CW(10)) dut_s (
    .clk_sys(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .cmd_init(cmd_init), .irq_line(irq_line[9:0]),
    .vga_vcount(v10), .hps_rise(r10), .lines_total(t10), .locked(l10));

  int n_assert = 0;
  int n_fail   = 0;
  int tog      = 0;
  bit go       = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the 16-bit instances, index 1 the 10-bit instance.
  int m_cnt[2], m_tot[2], maxv[2];
  bit m_lk[2], m_rise[2], m_en[2], m_seen[2], m_fired[2];
  bit pend_h, pend_v, prev_h, prev_v;

  task automatic model_step(input int i, input bit r, input bit c, input bit eh, input bit ev,
                            input int irq);
    int nxt, nt;
    bit hit;
    if (r) begin
      m_cnt[i] = 0; m_tot[i] = 0; m_lk[i] = 0; m_rise[i] = 0;
      m_en[i] = 0; m_seen[i] = 0; m_fired[i] = 0;
      return;
    end
    nt  = (m_cnt[i] >= maxv[i]) ? maxv[i] : m_cnt[i] + 1;
    nxt = ev ? 0 : (eh ? nt : m_cnt[i]);
    hit = (eh || ev) && (nxt == (irq & maxv[i]));
    if (ev) begin
      m_lk[i]  = (nt == m_tot[i]) && (m_tot[i] != 0);
      m_tot[i] = nt;
    end
    if (!c) begin
      m_en[i] = 0;
    end else if (!m_en[i]) begin
      m_en[i] = 1; m_seen[i] = 0; m_fired[i] = 0;
    end else begin
      if (ev) begin m_seen[i] = 1; m_fired[i] = 0; end
      if (m_seen[i] && hit && !m_fired[i]) begin
        m_rise[i] = ~m_rise[i];
        m_fired[i] = 1;
      end
    end
    m_cnt[i] = nxt;
  endtask

  // A sync edge seen on one clock takes effect on the outputs one clock later.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i, reset, cmd_init, pend_h, pend_v, int'(irq_line));
    if (reset) begin
      pend_h = 0; pend_v = 0; prev_h = 0; prev_v = 0;
    end else begin
      pend_h = hsync & ~prev_h;
      pend_v = vsync & ~prev_v;
      prev_h = hsync;
      prev_v = vsync;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : cmp
    logic prev_r;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (go) begin
        chk("vcount_p", v16, m_cnt[0]);
        chk("rise_p", r16, m_rise[0]);
        chk("total_p", t16, m_tot[0]);
        chk("locked_p", l16, m_lk[0]);
        chk("vcount_n", v16n, m_cnt[0]);
        chk("rise_n", r16n, m_rise[0]);
        chk("total_n", t16n, m_tot[0]);
        chk("locked_n", l16n, m_lk[0]);
        chk("vcount_s", v10, m_cnt[1]);
        chk("rise_s", r10, m_rise[1]);
        chk("total_s", t10, m_tot[1]);
        chk("locked_s", l10, m_lk[1]);
        if (r16 !== prev_r) tog++;
        prev_r = r16;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int gap();
    return $urandom_range(1, 2);
  endfunction

  task automatic pulse(input bit h, input bit v, input int g);
    hsync = h; vsync = v;
    @(negedge clk);
    hsync = 0; vsync = 0;
    repeat (g) @(negedge clk);
  endtask

  task automatic lines(input int n);
    for (int l = 0; l < n; l++) pulse(1'b1, 1'b0, gap());
  endtask

  task automatic vs(input bit with_h);
    pulse(with_h, 1'b1, gap());
  endtask

  task automatic frame(input int n, input int drop_at, input int raise_at);
    vs(1'b0);
    for (int l = 1; l < n; l++) begin
      if (l == drop_at) cmd_init = 1'b0;
      if (l == raise_at) cmd_init = 1'b1;
      pulse(1'b1, 1'b0, gap());
    end
  endtask

  initial begin : main
    int t0;
    maxv[0] = int'(LINE_MAX);
    maxv[1] = 1023;
    reset = 1; hsync = 0; vsync = 0; cmd_init = 0; irq_line = 16'd240;
    repeat (3) @(negedge clk);
    go = 1'b1;
    chk("reset_vcount", v16, 0);
    chk("reset_rise", r16, 0);
    chk("reset_total", t16, 0);
    chk("reset_locked", l16, 0);
    reset = 0; cmd_init = 1;

    // Scenario 1: partial frame then 262-line frames, irq_line 240.
    t0 = tog;
    lines(50);
    chk("partial_no_toggle", tog - t0, 0);
    frame(262, -1, -1);
    chk("f1_rise", r16, 1);
    chk("f1_total", t16, 51);
    frame(262, -1, -1);
    chk("f2_rise", r16, 0);
    chk("f2_total", t16, 262);
    chk("f2_locked", l16, 0);
    frame(262, -1, -1);
    chk("f3_total", t16, 262);
    chk("f3_locked", l16, 1);

    // Scenario 2: coincident hsync/vsync edge.
    hsync = 1; vsync = 1;
    @(negedge clk);
    hsync = 0; vsync = 0;
    @(negedge clk);
    chk("simul_vcount", v16, 0);
    pulse(1'b1, 1'b0, 1);
    @(negedge clk);
    chk("simul_next_line", v16, 1);
    lines(255);

    // Scenario 3: irq_line 0, then irq_line past the frame.
    irq_line = 16'd0; t0 = tog;
    repeat (3) frame(262, -1, -1);
    chk("irq0_toggles", tog - t0, 3);
    irq_line = 16'd300; t0 = tog;
    repeat (3) frame(262, -1, -1);
    chk("irq300_toggles", tog - t0, 0);

    // Scenario 4: cmd_init drop after a toggle and late re-enable.
    irq_line = 16'd200;
    frame(262, -1, -1);
    t0 = tog;
    frame(262, 230, -1);
    chk("drop_frame_toggles", tog - t0, 1);
    t0 = tog;
    frame(262, -1, 100);
    chk("reenable_frame_toggles", tog - t0, 0);
    frame(262, -1, -1);
    chk("next_frame_toggles", tog - t0, 1);

    // Scenario 5: height change and missing vsync.
    vs(1'b0);
    lines(262);
    vs(1'b0);
    chk("h263_total", t16, 263);
    chk("h263_locked", l16, 0);
    lines(262);
    vs(1'b0);
    chk("h263b_locked", l16, 1);
    lines(1100);
    chk("sat_small_vcount", v10, 1023);
    chk("nosat_big_vcount", v16, 1100);
    chk("sat_locked_hold", l16, 1);
    vs(1'b0);
    chk("sat_small_total", t10, 1023);

    // Scenario 6: reset mid-frame at line 150.
    irq_line = 16'd240;
    lines(150);
    reset = 1;
    @(negedge clk);
    chk("midrst_vcount", v16, 0);
    chk("midrst_rise", r16, 0);
    chk("midrst_total", t16, 0);
    chk("midrst_locked", l16, 0);
    reset = 0; t0 = tog;
    lines(111);
    chk("postrst_partial_toggles", tog - t0, 0);
    frame(262, -1, -1);
    chk("postrst_frame_toggles", tog - t0, 1);
    frame(262, -1, -1);

    // Random phase: heights, irq_line, cmd_init, coincident edges.
    for (int f = 0; f < 8; f++) begin
      irq_line = 16'($urandom_range(0, 310));
      cmd_init = ($urandom_range(0, 3) != 0);
      vs(1'($urandom_range(0, 1)));
      lines($urandom_range(199, 299));
    end
    vs(1'b0);
    lines(5);

    go = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
